// File: rtl/conv_acc_pkg.sv
// rtl/conv_acc_pkg.sv - shared types and derived constants for the conv row sequencer
package conv_acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam int DEF_IFM_WIDTH    = 8;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_KERNEL_SIZE  = 3;
    localparam int DEF_ROW_LEN      = 9;
    localparam int DEF_PE_LAT       = 1;
    localparam int DEF_RD_LEAD      = 1;
    localparam int DEF_ROW_GAP      = 1;

    // Output row length and one pass length (stream + gap)
    function automatic int out_len(input int row_len, input int k);
        return row_len - k + 1;
    endfunction

    function automatic int pass_len(input int row_len, input int row_gap);
        return row_len + row_gap;
    endfunction

    localparam int OUT_LEN   = out_len(DEF_ROW_LEN, DEF_KERNEL_SIZE);
    localparam int PASS_LEN  = pass_len(DEF_ROW_LEN, DEF_ROW_GAP);
    localparam int WGT_BUS_W = DEF_WEIGHT_WIDTH * DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

endpackage

// File: rtl/conv_row_sequencer_if.sv
// rtl/conv_row_sequencer_if.sv - ifm source stream between source and sequencer
interface conv_row_sequencer_if
    import conv_acc_pkg::*;
#(
    parameter int IFM_WIDTH = DEF_IFM_WIDTH
);
    logic [IFM_WIDTH-1:0] ifm_in;
    logic                 ifm_in_valid;
    logic                 ifm_in_ready;

    modport master (output ifm_in, output ifm_in_valid, input ifm_in_ready);
    modport slave  (input ifm_in, input ifm_in_valid, output ifm_in_ready);
endinterface

// File: rtl/seq_window_gen.sv
// rtl/seq_window_gen.sv - enable window over an inclusive pass-cycle range
module seq_window_gen #(
    parameter int TW = 4
) (
    input  logic          en,
    input  logic [TW-1:0] t,
    input  logic [TW-1:0] t_start,
    input  logic [TW-1:0] t_stop,
    output logic          win
);
    // Window is open while t lies in [t_start, t_stop]
    assign win = en && (t >= t_start) && (t <= t_stop);
endmodule

// File: rtl/conv_row_sequencer.sv
// rtl/conv_row_sequencer.sv - row-tile sequencer feeding the 3x3 PE array and psum FIFOs
module conv_row_sequencer
    import conv_acc_pkg::*;
#(
    parameter int IFM_WIDTH    = DEF_IFM_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int ROW_LEN      = DEF_ROW_LEN,
    parameter int PE_LAT       = DEF_PE_LAT,
    parameter int RD_LEAD      = DEF_RD_LEAD,
    parameter int ROW_GAP      = DEF_ROW_GAP
) (
    input  logic                                          clk1,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wgt_in,
    conv_row_sequencer_if.slave                           src,
    output logic [IFM_WIDTH-1:0]                          ifm,
    output logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wgt,
    output logic                                          set_ifm,
    output logic                                          set_wgt,
    output logic                                          set_reg,
    output logic                                          wr_en_0,
    output logic                                          wr_en_1,
    output logic                                          wr_en_2,
    output logic                                          rd_en_0,
    output logic                                          rd_en_1,
    output logic                                          rd_en_2,
    output logic                                          rd_clr,
    output logic                                          wr_clr,
    output logic                                          out_valid,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err
);
    localparam int OLEN = out_len(ROW_LEN, KERNEL_SIZE);
    localparam int PLEN = pass_len(ROW_LEN, ROW_GAP);
    localparam int TW   = $clog2(ROW_LEN + ROW_GAP + 1);

    localparam logic [TW-1:0] T_PASS_END   = TW'(PLEN - 1);
    localparam logic [TW-1:0] T_STREAM_END = TW'(ROW_LEN - 1);
    localparam logic [TW-1:0] T_DRAIN_END  = TW'(OLEN - 1);
    localparam logic [TW-1:0] WR_START     = TW'(KERNEL_SIZE - 1 + PE_LAT);
    localparam logic [TW-1:0] WR_STOP      = TW'(ROW_LEN - 1 + PE_LAT);
    localparam logic [TW-1:0] RD_START     = TW'(KERNEL_SIZE - 1 + PE_LAT - RD_LEAD);
    localparam logic [TW-1:0] RD_STOP      = TW'(ROW_LEN - 1 + PE_LAT - RD_LEAD);
    localparam logic [1:0]    P_LAST       = 2'(KERNEL_SIZE - 1);

    // Three psum FIFOs tie the kernel to 3; timing windows must stay inside a pass
    if (KERNEL_SIZE != 3) begin : g_bad_kernel
        $error("conv_row_sequencer: KERNEL_SIZE must be 3");
    end
    if (ROW_LEN < 3 || ROW_LEN > 255) begin : g_bad_row_len
        $error("conv_row_sequencer: ROW_LEN must be in 3..255");
    end
    if (RD_LEAD < 0 || RD_LEAD > KERNEL_SIZE - 1 + PE_LAT) begin : g_bad_rd_lead
        $error("conv_row_sequencer: RD_LEAD out of range");
    end
    if (ROW_GAP < PE_LAT) begin : g_bad_row_gap
        $error("conv_row_sequencer: ROW_GAP must be >= PE_LAT");
    end

    seq_state_t    state;
    logic [TW-1:0] t;
    logic [1:0]    p;
    logic          in_pass;
    logic          in_stream;
    logic          wr_win;
    logic          rd_win;

    assign in_pass   = (state == ST_STREAM) || (state == ST_GAP);
    assign in_stream = (state == ST_STREAM);

    // Sequencer FSM: pass/cycle counters, weight latch, ifm register and status pulses
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            t         <= '0;
            p         <= '0;
            wgt       <= '0;
            ifm       <= '0;
            set_ifm   <= 1'b0;
            set_wgt   <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            set_ifm   <= 1'b0;
            set_wgt   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_valid <= rd_en_2;
            case (state)
                ST_IDLE: begin
                    t <= '0;
                    p <= '0;
                    if (start) begin
                        state <= ST_CLEAR;
                        wgt   <= wgt_in;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_STREAM;
                    t     <= '0;
                    p     <= '0;
                end
                ST_STREAM, ST_GAP: begin
                    if (in_stream && !src.ifm_in_valid) begin
                        // A starved row cannot be resumed; abandon the tile
                        state <= ST_IDLE;
                        err   <= 1'b1;
                        t     <= '0;
                        p     <= '0;
                    end else begin
                        if (in_stream) begin
                            ifm     <= src.ifm_in;
                            set_ifm <= 1'b1;
                            set_wgt <= 1'b1;
                        end
                        if (t == T_PASS_END) begin
                            t <= '0;
                            if (p == P_LAST) begin
                                state <= ST_DRAIN;
                            end else begin
                                p     <= p + 2'd1;
                                state <= ST_STREAM;
                            end
                        end else begin
                            t     <= t + 1'b1;
                            state <= (t >= T_STREAM_END) ? ST_GAP : ST_STREAM;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (t == T_DRAIN_END) begin
                        t     <= '0;
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    p     <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    seq_window_gen #(.TW(TW)) u_wr_win (
        .en      (in_pass),
        .t       (t),
        .t_start (WR_START),
        .t_stop  (WR_STOP),
        .win     (wr_win)
    );

    seq_window_gen #(.TW(TW)) u_rd_win (
        .en      (in_pass && (p != 2'd0)),
        .t       (t),
        .t_start (RD_START),
        .t_stop  (RD_STOP),
        .win     (rd_win)
    );

    // Pass p writes FIFO p and reads FIFO p-1; the drain empties FIFO 2
    assign wr_en_0 = wr_win && (p == 2'd0);
    assign wr_en_1 = wr_win && (p == 2'd1);
    assign wr_en_2 = wr_win && (p == 2'd2);
    assign rd_en_0 = rd_win && (p == 2'd1);
    assign rd_en_1 = rd_win && (p == 2'd2);
    assign rd_en_2 = (state == ST_DRAIN);

    assign busy             = (state != ST_IDLE);
    assign set_reg          = busy;
    assign rd_clr           = (state == ST_IDLE) || (state == ST_CLEAR);
    assign wr_clr           = (state == ST_IDLE) || (state == ST_CLEAR);
    assign src.ifm_in_ready = in_stream;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// tb/tb_conv_row_sequencer.sv - randomized self-checking bench for conv_row_sequencer
module tb_conv_row_sequencer;

    localparam int W       = 9;
    localparam int K       = 3;
    localparam int PE_LAT  = 1;
    localparam int RD_LEAD = 1;
    localparam int GAP     = 1;
    localparam int PLEN    = W + GAP;
    localparam int OLEN    = W - K + 1;
    localparam int D0      = 2 + K * PLEN;
    localparam int DONE_K  = D0 + OLEN;
    localparam int NK      = DONE_K + 6;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic [71:0] wgt_in;
    logic [7:0]  ifm;
    logic [71:0] wgt;
    logic        set_ifm, set_wgt, set_reg;
    logic        wr_en_0, wr_en_1, wr_en_2;
    logic        rd_en_0, rd_en_1, rd_en_2;
    logic        rd_clr, wr_clr, out_valid, busy, done, err;

    int errors = 0;
    int checks = 0;
    int en_cnt [0:5];
    int ov_cnt;
    int done_cnt;
    int err_cnt;
    logic [7:0] sent [0:63];

    conv_row_sequencer_if #(.IFM_WIDTH(8)) src_if ();

    conv_row_sequencer #(
        .IFM_WIDTH(8), .WEIGHT_WIDTH(8), .KERNEL_SIZE(K), .ROW_LEN(W),
        .PE_LAT(PE_LAT), .RD_LEAD(RD_LEAD), .ROW_GAP(GAP)
    ) dut (
        .clk1(clk1), .rst(rst), .start(start), .wgt_in(wgt_in), .src(src_if),
        .ifm(ifm), .wgt(wgt), .set_ifm(set_ifm), .set_wgt(set_wgt), .set_reg(set_reg),
        .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .wr_en_2(wr_en_2),
        .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .rd_clr(rd_clr), .wr_clr(wr_clr), .out_valid(out_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [15:0] observed();
        return {wr_en_2, wr_en_1, wr_en_0, rd_en_2, rd_en_1, rd_en_0, out_valid, busy,
                done, err, set_ifm, set_wgt, set_reg, rd_clr, wr_clr, src_if.ifm_in_ready};
    endfunction

    function automatic bit in_stream(int k);
        return (k >= 2) && (k < D0) && (((k - 2) % PLEN) < W);
    endfunction

    // Expected control outputs k cycles after the cycle in which start was accepted
    function automatic logic [15:0] exp_ctrl(int k, int stall_k);
        logic [2:0] wr, rd;
        bit ov, bsy, dn, er, sif, rdy, clr;
        int j, ps, t;
        wr = '0; rd = '0; ov = 0; dn = 0; er = 0; sif = 0; rdy = 0; bsy = 0; clr = 1;
        if (stall_k >= 0 && k > stall_k) begin
            er = (k == stall_k + 1);
        end else begin
            bsy = (k >= 1) && (k <= DONE_K);
            clr = (k < 2) || (k > DONE_K);
            if (k >= 2 && k < D0) begin
                j = k - 2; ps = j / PLEN; t = j % PLEN;
                rdy = (t < W);
                wr[ps] = (t >= K - 1 + PE_LAT) && (t <= W - 1 + PE_LAT);
                if (ps >= 1)
                    rd[ps-1] = (t >= K - 1 + PE_LAT - RD_LEAD) && (t <= W - 1 + PE_LAT - RD_LEAD);
            end
            rd[2] = rd[2] | ((k >= D0) && (k < D0 + OLEN));
            ov  = (k >= D0 + 1) && (k <= D0 + OLEN);
            dn  = (k == DONE_K);
            sif = in_stream(k - 1);
        end
        return {wr, rd, ov, bsy, dn, er, sif, sif, bsy, clr, clr, rdy};
    endfunction

    task automatic run_tile(input string name, input logic [71:0] w, input bit rows,
                            input int stall_k, input int restart_k);
        logic [15:0] obs, expv;
        logic [95:0] r96;
        logic [7:0]  data;
        for (int i = 0; i < 6; i++) en_cnt[i] = 0;
        ov_cnt = 0; done_cnt = 0; err_cnt = 0;
        for (int k = 0; k < NK; k++) begin
            obs  = observed();
            expv = exp_ctrl(k, stall_k);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s ctrl k=%0d got=%b exp=%b", name, k, obs, expv);
            end
            if (expv[5]) begin
                checks++;
                if (ifm !== sent[k-1]) begin
                    errors++;
                    $display("FAIL %s ifm k=%0d got=%h exp=%h", name, k, ifm, sent[k-1]);
                end
            end
            if (k >= 1) begin
                checks++;
                if (wgt !== w) begin
                    errors++;
                    $display("FAIL %s wgt k=%0d got=%h exp=%h", name, k, wgt, w);
                end
            end
            en_cnt[0] += int'(wr_en_0); en_cnt[1] += int'(wr_en_1); en_cnt[2] += int'(wr_en_2);
            en_cnt[3] += int'(rd_en_0); en_cnt[4] += int'(rd_en_1); en_cnt[5] += int'(rd_en_2);
            ov_cnt += int'(out_valid); done_cnt += int'(done); err_cnt += int'(err);
            r96 = {$urandom(), $urandom(), $urandom()};
            start  = (k == 0) || (k == restart_k);
            wgt_in = (k == 0) ? w : r96[71:0];
            src_if.ifm_in_valid = (k != stall_k);
            if (rows && in_stream(k)) data = 8'((k - 2) / PLEN + 1 + (k - 2) % PLEN);
            else                      data = 8'($urandom());
            src_if.ifm_in = data;
            sent[k] = data;
            @(negedge clk1);
        end
        start = 1'b0;
        src_if.ifm_in_valid = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst = 1'b1; start = 1'b0; wgt_in = '0;
        src_if.ifm_in = 8'h00; src_if.ifm_in_valid = 1'b0;
        repeat (2) @(negedge clk1);
        obs = observed();
        checks++;
        if (obs !== exp_ctrl(-1, -1) || ifm !== 8'h00 || wgt !== 72'h0) begin
            errors++;
            $display("FAIL reset_state got=%b ifm=%h wgt=%h exp=%b", obs, ifm, wgt, exp_ctrl(-1, -1));
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            src_if.ifm_in = 8'($urandom());
            src_if.ifm_in_valid = 1'($urandom());
            @(negedge clk1);
            obs = observed();
            checks++;
            if (obs !== exp_ctrl(-1, -1) || ifm !== 8'h00) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got=%b ifm=%h exp=%b", i, obs, ifm, exp_ctrl(-1, -1));
            end
        end
        src_if.ifm_in_valid = 1'b1;
    endtask

    task automatic test_full_tile();
        run_tile("full_tile", 72'h010203010203010203, 1'b1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (en_cnt[i] !== OLEN) begin
                errors++;
                $display("FAIL full_tile en_count[%0d] got=%0d exp=%0d", i, en_cnt[i], OLEN);
            end
        end
        checks++;
        if (ov_cnt !== OLEN || done_cnt !== 1) begin
            errors++;
            $display("FAIL full_tile ov/done got=%0d/%0d exp=%0d/1", ov_cnt, done_cnt, OLEN);
        end
    endtask

    task automatic test_random_tiles();
        logic [95:0] r96;
        for (int n = 0; n < 3; n++) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            run_tile("rand_tile", r96[71:0], 1'b0, -1, -1);
            checks++;
            if (done_cnt !== 1 || en_cnt[5] !== OLEN) begin
                errors++;
                $display("FAIL rand_tile done/drain got=%0d/%0d exp=1/%0d", done_cnt, en_cnt[5], OLEN);
            end
        end
    endtask

    task automatic test_stall();
        logic [95:0] r96;
        int sk;
        for (int n = 0; n < 3; n++) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            if (n == 0) sk = 2 + PLEN + 4;
            else        sk = 2 + int'($urandom_range(0, K - 1)) * PLEN + int'($urandom_range(0, W - 1));
            run_tile("stall", r96[71:0], 1'b0, sk, -1);
            checks++;
            if (err_cnt !== 1 || done_cnt !== 0) begin
                errors++;
                $display("FAIL stall err/done k=%0d got=%0d/%0d exp=1/0", sk, err_cnt, done_cnt);
            end
        end
    endtask

    task automatic test_start_busy();
        logic [95:0] r96;
        r96 = {$urandom(), $urandom(), $urandom()};
        run_tile("start_busy", r96[71:0], 1'b0, -1, 2 + PLEN + 3);
        checks++;
        if (done_cnt !== 1 || en_cnt[0] !== OLEN || en_cnt[3] !== OLEN || ov_cnt !== OLEN) begin
            errors++;
            $display("FAIL start_busy done=%0d wr0=%0d rd0=%0d ov=%0d exp=1/%0d", done_cnt,
                     en_cnt[0], en_cnt[3], ov_cnt, OLEN);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] obs;
        logic [95:0] r96;
        r96 = {$urandom(), $urandom(), $urandom()};
        start = 1'b1; wgt_in = r96[71:0];
        @(negedge clk1);
        start = 1'b0;
        repeat (D0 + 1) @(negedge clk1);
        checks++;
        if (rd_en_2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid in_drain got=%b exp=1", rd_en_2);
        end
        #2 rst = 1'b1;
        #1;
        obs = observed();
        checks++;
        if (obs !== exp_ctrl(-1, -1) || ifm !== 8'h00 || wgt !== 72'h0) begin
            errors++;
            $display("FAIL reset_mid async got=%b ifm=%h wgt=%h exp=%b", obs, ifm, wgt, exp_ctrl(-1, -1));
        end
        @(negedge clk1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1);
            obs = observed();
            checks++;
            if (obs !== exp_ctrl(-1, -1)) begin
                errors++;
                $display("FAIL reset_mid after cyc=%0d got=%b exp=%b", i, obs, exp_ctrl(-1, -1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_random_tiles();
        test_stall();
        test_start_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_row_sequencer.md
Name: conv_row_sequencer

Overview:
- Control sequencer directly upstream of the 3x3 PE-array top. Replaces hand-driven stimulus for one output-row tile.
- Latches a 3x3 weight set. Streams K input rows from an ifm source into the array.
- Generates the PE load strobes and the psum-FIFO write/read enables (wr_en_0..2, rd_en_0..2), then drains FIFO 2 as the final output row.
- One clock domain; the PE array's inverted clock is derived outside this block.

Parameters:
- IFM_WIDTH, 8: ifm sample width.
- WEIGHT_WIDTH, 8: weight width.
- KERNEL_SIZE, 3: kernel dimension. Fixed at 3 because there are three psum FIFOs; elaboration error otherwise.
- ROW_LEN, 9: ifm row length W. Range 3..255.
- PE_LAT, 1: cycles from ifm beat to valid psum at a PE-row output.
- RD_LEAD, 1: cycles the previous FIFO read precedes the current FIFO write. Must satisfy 0 <= RD_LEAD <= K-1+PE_LAT.
- ROW_GAP, 1: idle cycles between row passes. Must satisfy ROW_GAP >= PE_LAT.

Ports:
- clk1  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; sampled only in IDLE.
- wgt_in  in  72  packed 3x3 weights (WEIGHT_WIDTH*K*K); captured on accepted start.
- ifm_in  in  IFM_WIDTH  ifm source data.
- ifm_in_valid  in  1  source has a beat.
- ifm_in_ready  out  1  sequencer consumes the beat this cycle.
- ifm  out  IFM_WIDTH  ifm to the PE array (registered).
- wgt  out  72  weights to the PE array (registered copy of wgt_in).
- set_ifm, set_wgt, set_reg  out  1 each  PE load strobes.
- wr_en_0, wr_en_1, wr_en_2  out  1 each  psum FIFO write enables.
- rd_en_0, rd_en_1, rd_en_2  out  1 each  psum FIFO read enables.
- rd_clr, wr_clr  out  1 each  FIFO pointer clears.
- out_valid  out  1  final-row psum present on the array output (equals the rd_en_2 drain window delayed 1 cycle).
- busy, done, err  out  1 each  status; done and err are 1-cycle pulses.

Behaviour:
- Reset: all outputs 0, except rd_clr = wr_clr = 1. FSM goes to IDLE; counters cleared; wgt and ifm registers cleared. Reset mid-operation aborts immediately, with no drain.
- States:
  - IDLE: rd_clr = wr_clr = 1. On start go to CLEAR and latch wgt_in.
  - CLEAR: 1 cycle, clears held high. Then STREAM with pass p = 0.
  - STREAM: W cycles.
  - GAP: ROW_GAP cycles. If p < K-1, increment p and return to STREAM; else go to DRAIN.
  - DRAIN: W-K+1 cycles.
  - DONE: 1 cycle; done = 1. Then IDLE.
- busy is 1 in every state except IDLE.
- Pass cycle counter t runs 0..W-1+ROW_GAP across STREAM+GAP and resets each pass.
- STREAM:
  - ifm_in_ready = 1. Requires ifm_in_valid = 1 every cycle.
  - The accepted beat appears on ifm 1 cycle later, with set_ifm = set_wgt = 1 in that cycle.
- Stall:
  - ifm_in_valid = 0 in STREAM: err pulse, all enables deasserted next cycle, state goes to IDLE (clears reasserted).
  - No partial-row recovery.
- set_reg: 1 whenever busy, 0 in IDLE.
- Write window, pass p: wr_en_p = 1 for t in [K-1+PE_LAT, W-1+PE_LAT], giving exactly W-K+1 writes.
- Read window, pass p >= 1: rd_en_(p-1) = 1 for t in [K-1+PE_LAT-RD_LEAD, W-1+PE_LAT-RD_LEAD], giving W-K+1 reads. No reads in pass 0.
- DRAIN: rd_en_2 = 1 for all W-K+1 cycles; out_valid follows 1 cycle later.
- Enable exclusivity: at most one wr_en_x and at most one rd_en_x asserted per cycle.
- Counter widths: $clog2(W+ROW_GAP+1) for t; 2 bits for p.
- start while busy is ignored.

Decomposition:
- Shared package conv_acc_pkg holds:
  - the FSM state enum;
  - derived constants OUT_LEN = ROW_LEN-KERNEL_SIZE+1 and PASS_LEN = ROW_LEN+ROW_GAP;
  - WGT_BUS_W = WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE.
- One sub-module, seq_window_gen: compares t against a start/stop pair and emits one enable. Instantiated for the wr and rd windows and indexed by p.

Test Plan (W=9, K=3, PE_LAT=1, RD_LEAD=1, ROW_GAP=1; source always valid unless stated):
- Reset then idle: rst pulse -> all enables 0, rd_clr = wr_clr = 1, busy = 0; start never asserted -> no change over 50 cycles.
- Full tile: start with wgt_in = 72'h010203010203010203 and rows 1..9, 2..10, 3..11.
  - wr_en_0 at t = 3..9 of pass 0;
  - rd_en_0 and wr_en_1 at t = 2..8 and 3..9 of pass 1;
  - rd_en_1 and wr_en_2 likewise in pass 2.
- Drain and timing: in the same run, rd_en_2 is high 7 cycles and out_valid 7 cycles, each 1 cycle later. done fires 39 cycles after the start cycle (1+30+7+1). wgt equals the latched value throughout.
- Stall: ifm_in_valid dropped at pass 1, t = 4 -> err pulse next cycle, all wr/rd enables 0, back to IDLE with clears high.
- Start while busy: second start pulse during pass 1 -> ignored; single done; counts identical to the full-tile run.
- Reset mid-operation: rst asserted during DRAIN -> outputs return to reset values asynchronously, with no done pulse.
